pe_msg_feeder: RTL and testbench
================================

Name: pe_msg_feeder

Overview:
- Transmit-side companion to processing_element_array. Accepts column slices (one element per PE row) from the tile loader and buffers them in per-row FIFOs.
- Drives the array's per-row {is_weight, data} message ports, enforcing systolic skew: row r issues its k-th message strictly after row r-1 issued its k-th.
- Enforces tile framing: weights first, then activations terminated by a last flag.

Parameters:
NUM_ROWS, 2, PE rows driven (>=1)
BIT_WIDTH, 8, data bits per element
FIFO_DEPTH, 4, entries per row FIFO (power of 2, >=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_tile_msg  in  [BIT_WIDTH-1:0] x NUM_ROWS  slice data; element r goes to row r
i_tile_is_weight  in  1  slice is weights (1) or activations (0)
i_tile_last  in  1  final activation slice of tile
i_tile_val  in  1  slice valid
o_tile_rdy  out  1  slice accepted when val&&rdy
o_msg_send_msg  out  [BIT_WIDTH:0] x NUM_ROWS  {is_weight, data} per row, to array i_msg_recv_msg
o_msg_send_val  out  [NUM_ROWS-1:0]  per-row valid
i_msg_send_rdy  in  [NUM_ROWS-1:0]  per-row ready from array
o_err  out  1  sticky framing error
o_busy  out  1  any row FIFO non-empty

Behaviour:
- Reset (i_rst high at posedge): FIFOs empty; lead counters 0; state LOAD_W; o_err 0; o_msg_send_val all 0; o_busy 0; o_tile_rdy 1 in the cycle after reset. Reset mid-operation discards all buffered data with no further sends.
- o_tile_rdy = every row FIFO count < FIFO_DEPTH, from registered counts only. No pop bypass: a full FIFO holds rdy low even in a cycle where it pops.
- Accept pushes i_tile_msg[r] with is_weight into FIFO r, for all rows in the same cycle.
- Registered FIFO, no fall-through: an accepted slice is visible at row 0 output on the next cycle at the earliest.
- Skew: lead[r] for r>=1 counts messages sent by row r-1 minus row r.
  - Update: lead[r] += fire[r-1] - fire[r], where fire[r] = val[r] && rdy[r].
  - Range: 0..FIFO_DEPTH; width clog2(FIFO_DEPTH+1).
- o_msg_send_val[0] = FIFO0 non-empty. o_msg_send_val[r] = FIFOr non-empty && lead[r] > 0.
  - val never depends on i_msg_send_rdy. Once asserted, val and msg stay stable until fire.
  - With all rdy held high, row r emits k-th entry exactly r cycles after row 0.
- o_msg_send_msg[r] = FIFO r head; {1'b0, 0} when empty.
- Framing FSM, evaluated only on accept:
  - LOAD_W, is_weight=1: stay.
  - LOAD_W, is_weight=0: go STREAM_A (slice is first activation). If last=1 as well, stay LOAD_W.
  - STREAM_A, is_weight=0, last=0: stay.
  - STREAM_A, is_weight=0, last=1: go LOAD_W.
  - STREAM_A, is_weight=1: protocol error. Slice accepted but dropped (no push), o_err set, state unchanged.
  - i_tile_last with is_weight=1: ignored.
- o_err clears only on reset.
- o_busy = OR of FIFO non-empty flags.

Optional Feature:
- Macro PE_FEEDER_STATS_EN.
- Defined: adds output o_stall_cnt [31:0], reset 0. It increments each cycle i_tile_val=1 && o_tile_rdy=0, saturating at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
(Bench uses NUM_ROWS=2, BIT_WIDTH=8, FIFO_DEPTH=4.)
- Reset: hold i_rst 2 cycles -> val=2'b00, o_tile_rdy=1, o_err=0, o_busy=0, msgs 9'h000.
- Skew: all rdy=1; push weight slice {r0=0x03, r1=0x05} at cycle T.
  - Required: row0 val with 9'h103 at T+1 only.
  - Required: row1 val with 9'h105 at T+2 only.
  - Required: o_busy 0 at T+3.
- Back-pressure: rdy=2'b00; push 4 slices.
  - Required: o_tile_rdy=0 after the 4th; 5th held off; row1 val stays 0.
  - Release rdy=2'b11 -> both rows drain 4 messages each in order, row1 one cycle behind row0.
- Framing error: push weights, then activation 0x07, then weight 0x09.
  - Required: weight beat accepted, not emitted, o_err=1 sticky.
  - Required: activation with last=1 returns to LOAD_W, after which weights are accepted with no new error.
- Reset mid-stream: 3 slices buffered, rdy=0, assert i_rst.
  - Required: next cycle val=0, o_busy=0, o_tile_rdy=1, lead counters 0.
  - Required: a new slice then follows the skew scenario timing.
- Stats (PE_FEEDER_STATS_EN): fill FIFOs, hold i_tile_val high 5 cycles with rdy low -> o_stall_cnt=5.

Source files
------------

// File: rtl/pe_msg_feeder.sv
// Feeds per-row {is_weight, data} messages into processing_element_array with systolic skew
// and weight/activation tile framing. Define PE_FEEDER_STATS_EN to add the o_stall_cnt output.
module pe_msg_feeder #(
  parameter int NUM_ROWS   = 2,
  parameter int BIT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_ROWS*BIT_WIDTH-1:0]     i_tile_msg,
  input  logic                              i_tile_is_weight,
  input  logic                              i_tile_last,
  input  logic                              i_tile_val,
  output logic                              o_tile_rdy,
  output logic [NUM_ROWS*(BIT_WIDTH+1)-1:0] o_msg_send_msg,
  output logic [NUM_ROWS-1:0]               o_msg_send_val,
  input  logic [NUM_ROWS-1:0]               i_msg_send_rdy,
  output logic                              o_err,
  output logic                              o_busy
`ifdef PE_FEEDER_STATS_EN
  ,
  output logic [31:0]                       o_stall_cnt
`endif
);

  localparam int MW = BIT_WIDTH + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {LOAD_W, STREAM_A} state_t;

  state_t              state, state_nxt;
  logic                accept, drop, push;
  logic [MW-1:0]       mem    [NUM_ROWS][FIFO_DEPTH];
  logic [PW-1:0]       rd_ptr [NUM_ROWS];
  logic [PW-1:0]       wr_ptr [NUM_ROWS];
  logic [CW-1:0]       count  [NUM_ROWS];
  logic [CW-1:0]       lead   [NUM_ROWS];
  logic [NUM_ROWS-1:0] not_empty, not_full, fire;

  // Ready comes from registered counts only, so a popping full FIFO still blocks the slice.
  always_comb begin
    not_empty = '0;
    not_full  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      not_empty[r] = (count[r] != '0);
      not_full[r]  = (count[r] < DEPTH_C);
    end
  end

  assign o_tile_rdy = &not_full;
  assign accept     = i_tile_val && o_tile_rdy;
  assign push       = accept && !drop;
  assign o_busy     = |not_empty;

  // Row r may only present its k-th entry once row r-1 has sent its k-th (lead > 0).
  always_comb begin
    o_msg_send_val = '0;
    o_msg_send_msg = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      o_msg_send_val[r] = not_empty[r] && ((r == 0) || (lead[r] != '0));
      o_msg_send_msg[r*MW +: MW] = not_empty[r] ? mem[r][rd_ptr[r]] : '0;
    end
  end

  assign fire = o_msg_send_val & i_msg_send_rdy;

  always_comb begin
    state_nxt = state;
    drop      = 1'b0;
    if (accept) begin
      case (state)
        LOAD_W: begin
          if (!i_tile_is_weight && !i_tile_last) state_nxt = STREAM_A;
        end
        STREAM_A: begin
          if (i_tile_is_weight) drop = 1'b1;
          else if (i_tile_last) state_nxt = LOAD_W;
        end
        default: state_nxt = LOAD_W;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= LOAD_W;
      o_err <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        rd_ptr[r] <= '0;
        wr_ptr[r] <= '0;
        count[r]  <= '0;
        lead[r]   <= '0;
      end
    end else begin
      state <= state_nxt;
      if (drop) o_err <= 1'b1;
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (push)    wr_ptr[r] <= wr_ptr[r] + PW'(1);
        if (fire[r]) rd_ptr[r] <= rd_ptr[r] + PW'(1);
        if (push && !fire[r])      count[r] <= count[r] + CW'(1);
        else if (!push && fire[r]) count[r] <= count[r] - CW'(1);
      end
      for (int r = 1; r < NUM_ROWS; r++) begin
        if (fire[r-1] && !fire[r])      lead[r] <= lead[r] + CW'(1);
        else if (!fire[r-1] && fire[r]) lead[r] <= lead[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (push) mem[r][wr_ptr[r]] <= {i_tile_is_weight, i_tile_msg[r*BIT_WIDTH +: BIT_WIDTH]};
    end
  end

`ifdef PE_FEEDER_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) o_stall_cnt <= '0;
    else if (i_tile_val && !o_tile_rdy) o_stall_cnt <= sat_inc(o_stall_cnt);
  end
`endif

endmodule

// File: tb/tb_pe_msg_feeder.sv
// Directed bench for pe_msg_feeder: reset, skew, back-pressure, framing error, mid-stream reset.
module tb_pe_msg_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tile_msg;
  logic        tile_is_weight, tile_last, tile_val;
  logic        tile_rdy;
  logic [17:0] send_msg;
  logic [1:0]  send_val;
  logic [1:0]  send_rdy;
  logic        err, busy;
`ifdef PE_FEEDER_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_msg_feeder #(.NUM_ROWS(2), .BIT_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_tile_msg       (tile_msg),
    .i_tile_is_weight (tile_is_weight),
    .i_tile_last      (tile_last),
    .i_tile_val       (tile_val),
    .o_tile_rdy       (tile_rdy),
    .o_msg_send_msg   (send_msg),
    .o_msg_send_val   (send_val),
    .i_msg_send_rdy   (send_rdy),
    .o_err            (err),
    .o_busy           (busy)
`ifdef PE_FEEDER_STATS_EN
    ,
    .o_stall_cnt      (stall_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d1, input logic [7:0] d0, input logic w, input logic last);
    tile_msg       = {d1, d0};
    tile_is_weight = w;
    tile_last      = last;
    tile_val       = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] e0, e1;
    logic       v0, v1;

    rst = 1'b1; tile_msg = '0; tile_is_weight = 1'b0; tile_last = 1'b0;
    tile_val = 1'b0; send_rdy = 2'b11;
    tick; tick;
    rst = 1'b0;
    chk("rst_val",  send_val, 2'b00);
    chk("rst_rdy",  tile_rdy, 1'b1);
    chk("rst_err",  err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_msg",  send_msg, 18'h0);

    // Skew with rdy high
    drive(8'h05, 8'h03, 1'b1, 1'b0);
    chk("skew_rdy", tile_rdy, 1'b1);
    tick; tile_val = 1'b0;
    chk("skew_t1_val",  send_val, 2'b01);
    chk("skew_t1_msg0", send_msg[8:0], 9'h103);
    tick;
    chk("skew_t2_val",  send_val, 2'b10);
    chk("skew_t2_msg1", send_msg[17:9], 9'h105);
    chk("skew_t2_msg0", send_msg[8:0], 9'h000);
    tick;
    chk("skew_t3_busy", busy, 1'b0);
    chk("skew_t3_val",  send_val, 2'b00);

    // Back-pressure: fill all four entries
    send_rdy = 2'b00;
    for (int k = 0; k < 4; k++) begin
      drive(8'h20 + 8'(k), 8'h10 + 8'(k), 1'b1, 1'b0);
      chk("bp_push_rdy", tile_rdy, 1'b1);
      tick;
    end
    chk("bp_full_rdy", tile_rdy, 1'b0);
    chk("bp_full_val", send_val, 2'b01);
    chk("bp_full_msg0", send_msg[8:0], 9'h110);
    drive(8'h2F, 8'h1F, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp_hold_rdy", tile_rdy, 1'b0);
      chk("bp_hold_val1", send_val[1], 1'b0);
    end
`ifdef PE_FEEDER_STATS_EN
    chk("stats_stall", stall_cnt, 32'd5);
`endif
    tile_val = 1'b0;
    send_rdy = 2'b11;
    for (int k = 0; k < 6; k++) begin
      v0 = (k < 4);
      v1 = (k >= 1) && (k <= 4);
      e0 = {1'b1, 8'h10 + 8'(k)};
      e1 = {1'b1, 8'h20 + 8'(k) - 8'd1};
      chk("drain_val", send_val, {v1, v0});
      if (v0) chk("drain_msg0", send_msg[8:0], e0);
      if (v1) chk("drain_msg1", send_msg[17:9], e1);
      tick;
    end
    chk("drain_busy", busy, 1'b0);

    // Framing error: weight, activation, then an illegal weight
    drive(8'h30, 8'h30, 1'b1, 1'b0);
    tick;
    drive(8'h07, 8'h07, 1'b0, 1'b0);
    tick;
    chk("frm_act_msg0", send_msg[8:0], 9'h007);
    chk("frm_w_msg1",   send_msg[17:9], 9'h130);
    drive(8'h09, 8'h09, 1'b1, 1'b0);
    chk("frm_bad_rdy", tile_rdy, 1'b1);
    tick; tile_val = 1'b0;
    chk("frm_err",      err, 1'b1);
    chk("frm_drop_val", send_val, 2'b10);
    chk("frm_drop_msg0", send_msg[8:0], 9'h000);
    chk("frm_act_msg1", send_msg[17:9], 9'h007);
    tick;
    chk("frm_drained", busy, 1'b0);
    chk("frm_err_sticky", err, 1'b1);
    drive(8'h0B, 8'h0B, 1'b0, 1'b1);
    tick;
    chk("frm_last_msg0", send_msg[8:0], 9'h00B);
    drive(8'h0D, 8'h0D, 1'b1, 1'b0);
    tick; tile_val = 1'b0;
    chk("frm_reload_val0", send_val[0], 1'b1);
    chk("frm_reload_msg0", send_msg[8:0], 9'h10D);
    chk("frm_err_still",   err, 1'b1);
    tick;
    chk("frm_reload_msg1", send_msg[17:9], 9'h10D);
    tick;
    chk("frm_end_busy", busy, 1'b0);

    // Reset mid-stream with a non-zero lead on row 1
    send_rdy = 2'b01;
    for (int k = 0; k < 3; k++) begin
      drive(8'h50 + 8'(k), 8'h40 + 8'(k), 1'b1, 1'b0);
      tick;
    end
    tile_val = 1'b0;
    send_rdy = 2'b00;
    chk("mid_val",  send_val, 2'b11);
    chk("mid_busy", busy, 1'b1);
    chk("mid_msg0", send_msg[8:0], 9'h142);
    chk("mid_msg1", send_msg[17:9], 9'h150);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_val",  send_val, 2'b00);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_rdy",  tile_rdy, 1'b1);
    chk("mrst_err",  err, 1'b0);
    chk("mrst_msg",  send_msg, 18'h0);
    send_rdy = 2'b11;
    drive(8'h55, 8'h53, 1'b1, 1'b0);
    tick; tile_val = 1'b0;
    chk("mrst_t1_val",  send_val, 2'b01);
    chk("mrst_t1_msg0", send_msg[8:0], 9'h153);
    tick;
    chk("mrst_t2_val",  send_val, 2'b10);
    chk("mrst_t2_msg1", send_msg[17:9], 9'h155);
    tick;
    chk("mrst_t3_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
